// File: rtl/sd_init_ctrl.sv
// SD card power-up / identification sequencer driving the CMD line driver.
// Walks CMD0..ACMD6, checks each response, latches RCA/OCR/CSD and flags 4-bit mode.
module sd_init_ctrl #(
    parameter int INIT_CLKS  = 80,
    parameter int TIMEOUT    = 2048,
    parameter int CMD0_WAIT  = 64,
    parameter int ACMD41_MAX = 1000
) (
    input  logic         iclk,
    input  logic         irst_n,
    input  logic         istart,
    output logic         ocmd_start,
    output logic [5:0]   ocmd_index,
    output logic [31:0]  ocmd_arg,
    input  logic         icmd_done,
    input  logic [119:0] icmd_resp,
    output logic [15:0]  orca,
    output logic [119:0] ocsd,
    output logic         ohcs,
    output logic         owide,
    output logic         odone,
    output logic         oerror,
    output logic [2:0]   oerr_code
);

    localparam int CNT_MAX = (INIT_CLKS > CMD0_WAIT) ? INIT_CLKS : CMD0_WAIT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int TMO_W   = $clog2(TIMEOUT + 1);
    localparam int RTY_W   = ($clog2(ACMD41_MAX + 1) > 10) ? $clog2(ACMD41_MAX + 1) : 10;

    localparam logic [RTY_W-1:0] RETRY_LIM = RTY_W'(ACMD41_MAX);

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_TIMEOUT = 3'd1;
    localparam logic [2:0] ERR_ECHO    = 3'd2;
    localparam logic [2:0] ERR_RETRY   = 3'd3;
    localparam logic [2:0] ERR_INDEX   = 3'd4;

    typedef enum logic [3:0] {
        S_IDLE,
        S_POWERUP,
        S_ISSUE,
        S_WAIT_FIXED,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t             r_state;
    logic [3:0]         r_step;
    logic [CNT_W-1:0]   r_cnt;
    logic [TMO_W-1:0]   r_tmo;
    logic [RTY_W-1:0]   r_retry;
    logic               r_start_d;
    logic               r_cmd_start;
    logic [5:0]         r_cmd_index;
    logic [31:0]        r_cmd_arg;
    logic [15:0]        r_rca;
    logic [119:0]       r_csd;
    logic               r_hcs;
    logic               r_wide;
    logic               r_done;
    logic               r_error;
    logic [2:0]         r_err_code;

    logic               w_start_edge;
    logic [5:0]         w_resp_idx;
    logic [31:0]        w_content;
    logic [2:0]         w_chk_code;
    logic [3:0]         w_next_step;
    logic [RTY_W-1:0]   w_retry_next;

    function automatic logic [5:0] step_index(input logic [3:0] step);
        case (step)
            4'd0:    step_index = 6'd0;
            4'd1:    step_index = 6'd8;
            4'd2:    step_index = 6'd55;
            4'd3:    step_index = 6'd41;
            4'd4:    step_index = 6'd2;
            4'd5:    step_index = 6'd3;
            4'd6:    step_index = 6'd9;
            4'd7:    step_index = 6'd7;
            4'd8:    step_index = 6'd55;
            4'd9:    step_index = 6'd6;
            default: step_index = 6'd0;
        endcase
    endfunction

    function automatic logic [31:0] step_arg(input logic [3:0] step, input logic [15:0] rca);
        case (step)
            4'd1:             step_arg = 32'h0000_01AA;
            4'd3:             step_arg = 32'h40FF_8000;
            4'd6, 4'd7, 4'd8: step_arg = {rca, 16'h0000};
            4'd9:             step_arg = 32'h0000_0002;
            default:          step_arg = 32'h0000_0000;
        endcase
    endfunction

    assign w_start_edge = istart & ~r_start_d;
    assign w_resp_idx   = icmd_resp[37:32];
    assign w_content    = icmd_resp[31:0];

    // Response validation for the current step; consumed only in CHECK.
    always_comb begin
        w_chk_code   = ERR_NONE;
        w_next_step  = r_step + 4'd1;
        w_retry_next = r_retry;
        case (r_step)
            4'd1: begin
                if (w_content[11:0] != 12'h1AA) w_chk_code = ERR_ECHO;
            end
            4'd2, 4'd5, 4'd7, 4'd8, 4'd9: begin
                if (w_resp_idx != r_cmd_index) w_chk_code = ERR_INDEX;
            end
            4'd3: begin
                if (!w_content[31]) begin
                    w_retry_next = (r_retry == '1) ? r_retry : r_retry + 1'b1;
                    w_next_step  = 4'd2;
                    if (w_retry_next >= RETRY_LIM) w_chk_code = ERR_RETRY;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge iclk) begin
        if (!irst_n) begin
            r_state     <= S_IDLE;
            r_step      <= 4'd0;
            r_cnt       <= '0;
            r_tmo       <= '0;
            r_retry     <= '0;
            r_start_d   <= 1'b0;
            r_cmd_start <= 1'b0;
            r_cmd_index <= 6'd0;
            r_cmd_arg   <= 32'h0;
            r_rca       <= 16'h0;
            r_csd       <= '0;
            r_hcs       <= 1'b0;
            r_wide      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_err_code  <= ERR_NONE;
        end else begin
            r_start_d <= istart;
            case (r_state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (w_start_edge) begin
                        r_done     <= 1'b0;
                        r_error    <= 1'b0;
                        r_err_code <= ERR_NONE;
                        r_retry    <= '0;
                        r_step     <= 4'd0;
                        r_cnt      <= CNT_W'(INIT_CLKS - 1);
                        r_state    <= S_POWERUP;
                    end
                end
                S_POWERUP: begin
                    if (r_cnt > CNT_W'(1)) r_cnt <= r_cnt - 1'b1;
                    else                   r_state <= S_ISSUE;
                end
                S_ISSUE: begin
                    r_cmd_start <= 1'b1;
                    r_cmd_index <= step_index(r_step);
                    r_cmd_arg   <= step_arg(r_step, r_rca);
                    r_tmo       <= TMO_W'(TIMEOUT);
                    if (r_step == 4'd0) begin
                        // ISSUE itself is one of the CMD0_WAIT clocks between pulses
                        r_cnt   <= CNT_W'(CMD0_WAIT - 1);
                        r_state <= S_WAIT_FIXED;
                    end else begin
                        r_state <= S_WAIT_BUSY;
                    end
                end
                S_WAIT_FIXED: begin
                    r_cmd_start <= 1'b0;
                    if (r_cnt > CNT_W'(1)) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_step  <= 4'd1;
                        r_state <= S_ISSUE;
                    end
                end
                S_WAIT_BUSY: begin
                    r_cmd_start <= 1'b0;
                    if (r_tmo <= TMO_W'(1)) begin
                        r_error    <= 1'b1;
                        r_err_code <= ERR_TIMEOUT;
                        r_state    <= S_ERROR;
                    end else begin
                        r_tmo <= r_tmo - 1'b1;
                        if (!icmd_done) r_state <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    r_cmd_start <= 1'b0;
                    if (r_tmo <= TMO_W'(1)) begin
                        r_error    <= 1'b1;
                        r_err_code <= ERR_TIMEOUT;
                        r_state    <= S_ERROR;
                    end else begin
                        r_tmo <= r_tmo - 1'b1;
                        if (icmd_done) r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (r_step == 4'd3) r_hcs <= w_content[30];
                    if (w_chk_code != ERR_NONE) begin
                        r_error    <= 1'b1;
                        r_err_code <= w_chk_code;
                        r_state    <= S_ERROR;
                    end else begin
                        r_retry <= w_retry_next;
                        if (r_step == 4'd5) r_rca <= w_content[31:16];
                        if (r_step == 4'd6) r_csd <= icmd_resp;
                        if (r_step == 4'd9) begin
                            r_wide  <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_step  <= w_next_step;
                            r_state <= S_ISSUE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ocmd_start = r_cmd_start;
    assign ocmd_index = r_cmd_index;
    assign ocmd_arg   = r_cmd_arg;
    assign orca       = r_rca;
    assign ocsd       = r_csd;
    assign ohcs       = r_hcs;
    assign owide      = r_wide;
    assign odone      = r_done;
    assign oerror     = r_error;
    assign oerr_code  = r_err_code;

endmodule

// File: tb/tb_sd_init_ctrl.sv
// Directed bench for sd_init_ctrl with a behavioural CMD driver / card model.
module tb_sd_init_ctrl;

    localparam int INIT_CLKS  = 80;
    localparam int TIMEOUT    = 2048;
    localparam int CMD0_WAIT  = 64;
    localparam int ACMD41_MAX = 1000;

    localparam logic [119:0] CSD_PAT = 120'h400E00325B5900003B377F800A4040;
    localparam logic [119:0] CID_PAT = {60'h0123456789ABCDE, 60'hFEDCBA987654321};

    logic         iclk = 1'b0;
    logic         irst_n = 1'b0;
    logic         istart = 1'b0;
    logic         icmd_done = 1'b1;
    logic [119:0] icmd_resp = '0;
    logic         ocmd_start;
    logic [5:0]   ocmd_index;
    logic [31:0]  ocmd_arg;
    logic [15:0]  orca;
    logic [119:0] ocsd;
    logic         ohcs;
    logic         owide;
    logic         odone;
    logic         oerror;
    logic [2:0]   oerr_code;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [5:0]  log_idx [0:63];
    logic [31:0] log_arg [0:63];
    int          log_t   [0:63];
    int          n_cmds = 0;
    logic        bad_cmd8 = 1'b0;
    logic        hang_cmd2 = 1'b0;
    int          acmd41_cnt = 0;
    int          long_pulse = 0;

    sd_init_ctrl #(
        .INIT_CLKS (INIT_CLKS),
        .TIMEOUT   (TIMEOUT),
        .CMD0_WAIT (CMD0_WAIT),
        .ACMD41_MAX(ACMD41_MAX)
    ) dut (
        .iclk      (iclk),
        .irst_n    (irst_n),
        .istart    (istart),
        .ocmd_start(ocmd_start),
        .ocmd_index(ocmd_index),
        .ocmd_arg  (ocmd_arg),
        .icmd_done (icmd_done),
        .icmd_resp (icmd_resp),
        .orca      (orca),
        .ocsd      (ocsd),
        .ohcs      (ohcs),
        .owide     (owide),
        .odone     (odone),
        .oerror    (oerror),
        .oerr_code (oerr_code)
    );

    always #5 iclk = ~iclk;

    always @(posedge iclk) cyc <= cyc + 1;

    // Start pulse width monitor
    initial begin : pulse_mon
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge iclk);
            if (ocmd_start === 1'b1 && prev === 1'b1) long_pulse++;
            prev = ocmd_start;
        end
    end

    // CMD driver + card model: goes busy on a start pulse, answers 5 clocks later
    initial begin : card_model
        logic [5:0]  idx;
        logic [31:0] content;
        forever begin
            @(negedge iclk);
            if (ocmd_start === 1'b1) begin
                idx = ocmd_index;
                if (n_cmds < 64) begin
                    log_idx[n_cmds] = idx;
                    log_arg[n_cmds] = ocmd_arg;
                    log_t[n_cmds]   = cyc;
                end
                n_cmds++;
                icmd_done = 1'b0;
                if (hang_cmd2 && idx == 6'd2) wait (hang_cmd2 == 1'b0);
                repeat (5) @(negedge iclk);
                content = 32'h0000_0900;
                case (idx)
                    6'd8:  content = bad_cmd8 ? 32'h0000_012A : 32'h0000_01AA;
                    6'd41: begin
                        content = (acmd41_cnt < 2) ? 32'h00FF_8000 : 32'hC0FF_8000;
                        acmd41_cnt++;
                    end
                    6'd3:  content = 32'hABCD_0500;
                    default: ;
                endcase
                if (idx == 6'd0)      icmd_resp = '0;
                else if (idx == 6'd2) icmd_resp = CID_PAT;
                else if (idx == 6'd9) icmd_resp = CSD_PAT;
                else                  icmd_resp = {82'h0, idx, content};
                icmd_done = 1'b1;
            end
        end
    end

    task automatic apply_reset();
        @(negedge iclk);
        irst_n = 1'b0;
        istart = 1'b0;
        repeat (3) @(negedge iclk);
        irst_n = 1'b1;
    endtask

    task automatic pulse_start(output int t0);
        @(negedge iclk);
        istart = 1'b1;
        @(negedge iclk);
        t0 = cyc;
        istart = 1'b0;
    endtask

    task automatic wait_end(input int budget, output bit ok, output int t);
        ok = 1'b0;
        t  = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge iclk);
            if (odone === 1'b1 || oerror === 1'b1) begin
                ok = 1'b1;
                t  = cyc;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge iclk);
        irst_n = 1'b0;
        istart = 1'b0;
        repeat (3) @(negedge iclk);
        n_checks++; if (ocmd_start !== 1'b0) begin n_fail++; $display("FAIL reset_start got %b want 0", ocmd_start); end
        n_checks++; if (ocmd_index !== 6'd0) begin n_fail++; $display("FAIL reset_index got %0d want 0", ocmd_index); end
        n_checks++; if (ocmd_arg !== 32'h0) begin n_fail++; $display("FAIL reset_arg got %h want 0", ocmd_arg); end
        n_checks++; if (orca !== 16'h0) begin n_fail++; $display("FAIL reset_rca got %h want 0", orca); end
        n_checks++; if (ocsd !== 120'h0) begin n_fail++; $display("FAIL reset_csd got %h want 0", ocsd); end
        n_checks++; if (ohcs !== 1'b0) begin n_fail++; $display("FAIL reset_hcs got %b want 0", ohcs); end
        n_checks++; if (owide !== 1'b0) begin n_fail++; $display("FAIL reset_wide got %b want 0", owide); end
        n_checks++; if (odone !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", odone); end
        n_checks++; if (oerror !== 1'b0) begin n_fail++; $display("FAIL reset_error got %b want 0", oerror); end
        n_checks++; if (oerr_code !== 3'd0) begin n_fail++; $display("FAIL reset_code got %0d want 0", oerr_code); end
        irst_n = 1'b1;
    endtask

    task automatic test_full_init();
        int t0, t_end;
        bit ok;
        logic [5:0]  exp_idx [0:13];
        logic [31:0] exp_arg [0:13];
        exp_idx = '{6'd0, 6'd8, 6'd55, 6'd41, 6'd55, 6'd41, 6'd55, 6'd41,
                    6'd2, 6'd3, 6'd9, 6'd7, 6'd55, 6'd6};
        exp_arg = '{32'h0, 32'h1AA, 32'h0, 32'h40FF8000, 32'h0, 32'h40FF8000,
                    32'h0, 32'h40FF8000, 32'h0, 32'h0, 32'hABCD0000, 32'hABCD0000,
                    32'hABCD0000, 32'h2};
        bad_cmd8 = 1'b0; hang_cmd2 = 1'b0; acmd41_cnt = 0;
        apply_reset();
        n_cmds = 0; long_pulse = 0;
        pulse_start(t0);
        wait_end(3000, ok, t_end);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL full_finish got no end within 3000 clocks want odone"); end
        n_checks++; if (log_t[0] - t0 !== INIT_CLKS) begin n_fail++; $display("FAIL full_powerup_delay got %0d want %0d", log_t[0] - t0, INIT_CLKS); end
        n_checks++; if (log_t[1] - log_t[0] !== CMD0_WAIT) begin n_fail++; $display("FAIL full_cmd0_wait got %0d want %0d", log_t[1] - log_t[0], CMD0_WAIT); end
        n_checks++; if (n_cmds !== 14) begin n_fail++; $display("FAIL full_cmd_count got %0d want 14", n_cmds); end
        for (int i = 0; i < 14; i++) begin
            n_checks++; if (log_idx[i] !== exp_idx[i]) begin n_fail++; $display("FAIL full_idx[%0d] got %0d want %0d", i, log_idx[i], exp_idx[i]); end
            n_checks++; if (log_arg[i] !== exp_arg[i]) begin n_fail++; $display("FAIL full_arg[%0d] got %h want %h", i, log_arg[i], exp_arg[i]); end
        end
        n_checks++; if (odone !== 1'b1) begin n_fail++; $display("FAIL full_done got %b want 1", odone); end
        n_checks++; if (oerror !== 1'b0) begin n_fail++; $display("FAIL full_error got %b want 0", oerror); end
        n_checks++; if (oerr_code !== 3'd0) begin n_fail++; $display("FAIL full_code got %0d want 0", oerr_code); end
        n_checks++; if (owide !== 1'b1) begin n_fail++; $display("FAIL full_wide got %b want 1", owide); end
        n_checks++; if (ohcs !== 1'b1) begin n_fail++; $display("FAIL full_hcs got %b want 1", ohcs); end
        n_checks++; if (orca !== 16'hABCD) begin n_fail++; $display("FAIL full_rca got %h want abcd", orca); end
        n_checks++; if (ocsd !== CSD_PAT) begin n_fail++; $display("FAIL full_csd got %h want %h", ocsd, CSD_PAT); end
        n_checks++; if (long_pulse !== 0) begin n_fail++; $display("FAIL full_pulse_width got %0d long pulses want 0", long_pulse); end
    endtask

    task automatic test_cmd8_bad();
        int t0, t_end;
        bit ok;
        bad_cmd8 = 1'b1; hang_cmd2 = 1'b0; acmd41_cnt = 0;
        apply_reset();
        n_cmds = 0;
        pulse_start(t0);
        wait_end(2000, ok, t_end);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL cmd8_finish got no end within 2000 clocks want oerror"); end
        n_checks++; if (oerror !== 1'b1) begin n_fail++; $display("FAIL cmd8_error got %b want 1", oerror); end
        n_checks++; if (oerr_code !== 3'd2) begin n_fail++; $display("FAIL cmd8_code got %0d want 2", oerr_code); end
        n_checks++; if (odone !== 1'b0) begin n_fail++; $display("FAIL cmd8_done got %b want 0", odone); end
        repeat (200) @(negedge iclk);
        n_checks++; if (n_cmds !== 2) begin n_fail++; $display("FAIL cmd8_cmd_count got %0d want 2", n_cmds); end
        n_checks++; if (owide !== 1'b0) begin n_fail++; $display("FAIL cmd8_wide got %b want 0", owide); end
        bad_cmd8 = 1'b0;
    endtask

    task automatic test_timeout();
        int t0, t_err;
        bit ok;
        bad_cmd8 = 1'b0; hang_cmd2 = 1'b1; acmd41_cnt = 0;
        apply_reset();
        n_cmds = 0;
        pulse_start(t0);
        wait_end(TIMEOUT + 1500, ok, t_err);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL tmo_finish got no end want oerror"); end
        n_checks++; if (log_idx[n_cmds-1] !== 6'd2) begin n_fail++; $display("FAIL tmo_last_cmd got %0d want 2", log_idx[n_cmds-1]); end
        n_checks++; if (t_err - log_t[n_cmds-1] !== TIMEOUT) begin n_fail++; $display("FAIL tmo_latency got %0d want %0d", t_err - log_t[n_cmds-1], TIMEOUT); end
        n_checks++; if (oerror !== 1'b1) begin n_fail++; $display("FAIL tmo_error got %b want 1", oerror); end
        n_checks++; if (oerr_code !== 3'd1) begin n_fail++; $display("FAIL tmo_code got %0d want 1", oerr_code); end
        n_checks++; if (odone !== 1'b0) begin n_fail++; $display("FAIL tmo_done got %b want 0", odone); end
        hang_cmd2 = 1'b0;
    endtask

    task automatic test_reset_mid();
        int t0, t_end;
        bit ok, seen;
        bad_cmd8 = 1'b0; hang_cmd2 = 1'b0; acmd41_cnt = 0;
        apply_reset();
        n_cmds = 0;
        pulse_start(t0);
        seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge iclk);
            if (n_cmds >= 10) seen = 1'b1;
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL mid_reach_cmd3 got %0d cmds want 10", n_cmds); end
        n_checks++; if (log_idx[9] !== 6'd3) begin n_fail++; $display("FAIL mid_cmd3_index got %0d want 3", log_idx[9]); end
        @(negedge iclk);
        irst_n = 1'b0;
        @(negedge iclk);
        n_checks++; if (ocmd_start !== 1'b0) begin n_fail++; $display("FAIL mid_start got %b want 0", ocmd_start); end
        n_checks++; if (ocmd_index !== 6'd0) begin n_fail++; $display("FAIL mid_index got %0d want 0", ocmd_index); end
        n_checks++; if (ocmd_arg !== 32'h0) begin n_fail++; $display("FAIL mid_arg got %h want 0", ocmd_arg); end
        n_checks++; if (ohcs !== 1'b0) begin n_fail++; $display("FAIL mid_hcs got %b want 0", ohcs); end
        n_checks++; if (orca !== 16'h0) begin n_fail++; $display("FAIL mid_rca got %h want 0", orca); end
        n_checks++; if (owide !== 1'b0 || odone !== 1'b0 || oerror !== 1'b0 || oerr_code !== 3'd0) begin
            n_fail++; $display("FAIL mid_status got wide=%b done=%b err=%b code=%0d want all 0", owide, odone, oerror, oerr_code);
        end
        irst_n = 1'b1;
        repeat (8) @(negedge iclk);
        n_cmds = 0;
        pulse_start(t0);
        wait_end(3000, ok, t_end);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL mid_restart_finish got no end want odone"); end
        n_checks++; if (log_t[0] - t0 !== INIT_CLKS) begin n_fail++; $display("FAIL mid_restart_delay got %0d want %0d", log_t[0] - t0, INIT_CLKS); end
        n_checks++; if (log_idx[0] !== 6'd0) begin n_fail++; $display("FAIL mid_restart_first_idx got %0d want 0", log_idx[0]); end
        n_checks++; if (odone !== 1'b1) begin n_fail++; $display("FAIL mid_restart_done got %b want 1", odone); end
        n_checks++; if (orca !== 16'hABCD) begin n_fail++; $display("FAIL mid_restart_rca got %h want abcd", orca); end
    endtask

    initial begin
        test_reset();
        test_full_init();
        test_cmd8_bad();
        test_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
